note_judge: RTL
===============

Name: note_judge

Overview:
- Receiving end of the note stream produced by the rhythm controller.
- Queues each spawned note (`note_valid`/`new_note` lane mask) with a spawn timestamp, and computes when that note reaches the judge line.
- Compares debounced player key presses against the head note and emits PERFECT/GOOD/MISS judgements.
- Maintains score, combo and max combo for the display/scoring logic.

Parameters:
- DEPTH, 16, note queue entries (power of two).
- TRAVEL_TICKS, 16'd8820, ticks from spawn until the note reaches the judge line.
- PERFECT_WIN, 16'd441, ± tick window for PERFECT.
- GOOD_WIN, 16'd1323, ± tick window for GOOD. Must be ≥ PERFECT_WIN, and TRAVEL_TICKS+GOOD_WIN must be < 32768.
- PERFECT_PTS, 16'd100, points per lane judged PERFECT.
- GOOD_PTS, 16'd50, points per lane judged GOOD.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick_en  in  1  one-cycle time-base strobe (audio sample rate)
- game_active  in  1  level from rhythm controller
- note_valid  in  1  one-cycle note spawn strobe
- new_note  in  4  lane mask of spawned note
- key_press  in  4  one-cycle per-lane press pulses, already debounced and synchronous
- judge_valid  out  1  one-cycle judgement strobe
- judge_result  out  2  0 none, 1 PERFECT, 2 GOOD, 3 MISS
- judge_lanes  out  4  lanes covered by this judgement
- score  out  16  saturating score
- combo  out  8  current combo, saturating at 255
- max_combo  out  8  highest combo this game
- overflow  out  1  sticky: a note was dropped because the queue was full
- game_done  out  1  one-cycle pulse when drain completes

Behaviour:
- Reset values: all outputs 0; state IDLE; queue empty; time counter `now` = 0.
- State IDLE:
  - A rising edge of game_active (registered previous value) clears the queue, `now`, score, combo, max_combo and overflow, then enters RUN.
  - Notes and keys are ignored in IDLE.
- State RUN:
  - `now` += 1 on each tick_en, 16-bit wrap.
  - note_valid with a nonzero new_note pushes {new_note, now} in the same cycle.
  - new_note == 0 is ignored.
  - A push while full drops the note and sets overflow.
  - A falling edge of game_active moves to DRAIN.
- State DRAIN:
  - `now` keeps ticking; pushes are ignored; judging continues.
  - When the queue is empty: pulse game_done one cycle, go to IDLE.
- Judging, evaluated every cycle in RUN and DRAIN on the non-empty head only:
  - delta = signed 16-bit (now − (stamp + TRAVEL_TICKS)), modular subtraction.
  - `rem` = remaining-lane mask of the head.
  - hit = key_press & rem.
  - If hit ≠ 0 and |delta| ≤ PERFECT_WIN: result PERFECT, score += PERFECT_PTS × popcount(hit).
  - Else if hit ≠ 0 and |delta| ≤ GOOD_WIN: result GOOD, score += GOOD_PTS × popcount(hit).
  - On PERFECT or GOOD: judge_lanes = hit, rem &= ~hit, combo += 1.
  - Hit outside the window with delta < −GOOD_WIN (early): no effect.
  - Else if delta > GOOD_WIN and rem ≠ 0: result MISS, judge_lanes = rem, combo = 0, head popped.
  - When rem becomes 0 the head is popped in the same cycle.
  - Key presses on lanes not in rem are ignored. Only the head is judged; at most one judgement per cycle.
- Outputs are registered. judge_valid/result/lanes appear 1 cycle after the deciding key_press or tick.
- max_combo updates to combo when combo exceeds it, 1 cycle later.
- score saturates at 16'hFFFF.
- Push and pop in the same cycle are both performed (count unchanged). A push to an empty queue is judgeable the next cycle.
- A rising edge of game_active while in DRAIN is taken as a restart: clear as in IDLE, enter RUN.
- rst_n low mid-game returns everything to reset values immediately.

Decomposition:
- Shared package `rhythm_pkg`:
  - judge_result codes (JR_NONE/PERFECT/GOOD/MISS)
  - state encodings (S_IDLE/S_RUN/S_DRAIN)
  - lane count constant 4
- Sub-module `note_fifo`:
  - Synchronous FIFO with parameter DEPTH; entry = {mask[3:0], stamp[15:0]}.
  - Signals: push, pop, clear, full, empty, head data.
  - Supports a writable head mask for `rem` updates.

Test Plan:
- Start game, spawn 4'b0001 at now=0, press lane0 when now=8820 → judge_valid, result=1, lanes=0001, score=100, combo=1.
- Spawn 4'b0011; press lanes 0 and 1 together at now=8820+900 → result=2, lanes=0011, score+=100, combo+1, queue empty.
- Spawn 4'b1000, press nothing → at now=8820+1324 result=3, lanes=1000, combo=0, max_combo retained.
- Press lane0 at now=8820−2000 (early) → no judgement. Then press at now=8820 → PERFECT.
- Spawn 17 notes with no presses → 17th dropped, overflow=1; the remaining 16 each produce MISS in order.
- Drop game_active with 2 notes queued → DRAIN; both notes MISS, then game_done pulses once and the block returns to IDLE. Asserting rst_n low mid-RUN zeroes score, combo and queue.

Source files
------------

// File: rtl/rhythm_pkg.sv
// Shared definitions for the rhythm game blocks: lane count, judgement codes,
// judge FSM states and a lane-mask popcount helper.
package rhythm_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    JR_NONE    = 2'd0,
    JR_PERFECT = 2'd1,
    JR_GOOD    = 2'd2,
    JR_MISS    = 2'd3
  } jr_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Number of set lanes in a mask; sized to hold LANES.
  function automatic logic [2:0] popcount_lanes(input logic [LANES-1:0] m);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < LANES; i++) begin
      c = c + {2'b00, m[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/note_fifo.sv
// Note queue: each entry holds a lane mask and its spawn timestamp. The head
// mask is writable so the judge can strike lanes off a partly-hit note.
module note_fifo
  import rhythm_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [LANES-1:0] push_mask,
  input  logic [15:0]      push_stamp,
  input  logic             pop,
  input  logic             head_we,
  input  logic [LANES-1:0] head_wmask,
  output logic             full,
  output logic             empty,
  output logic [LANES-1:0] head_mask,
  output logic [15:0]      head_stamp
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [LANES-1:0] mask_mem  [DEPTH];
  logic [15:0]      stamp_mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push & ~full;
  assign do_pop     = pop & ~empty;
  assign head_mask  = mask_mem[rd_ptr];
  assign head_stamp = stamp_mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; a push never lands on the head slot of a non-empty queue,
  // so the tail write and the head-mask rewrite never collide.
  always_ff @(posedge clk) begin
    if (!clear && do_push) begin
      mask_mem[wr_ptr]  <= push_mask;
      stamp_mem[wr_ptr] <= push_stamp;
    end
    if (!clear && head_we && !empty) begin
      mask_mem[rd_ptr] <= head_wmask;
    end
  end

endmodule

// File: rtl/note_judge.sv
// Note judge: timestamps spawned notes, judges key presses against the head
// note's arrival time and keeps score / combo / max combo.
module note_judge
  import rhythm_pkg::*;
#(
  parameter int          DEPTH        = 16,
  parameter logic [15:0] TRAVEL_TICKS = 16'd8820,
  parameter logic [15:0] PERFECT_WIN  = 16'd441,
  parameter logic [15:0] GOOD_WIN     = 16'd1323,
  parameter logic [15:0] PERFECT_PTS  = 16'd100,
  parameter logic [15:0] GOOD_PTS     = 16'd50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_en,
  input  logic             game_active,
  input  logic             note_valid,
  input  logic [LANES-1:0] new_note,
  input  logic [LANES-1:0] key_press,
  output logic             judge_valid,
  output logic [1:0]       judge_result,
  output logic [LANES-1:0] judge_lanes,
  output logic [15:0]      score,
  output logic [7:0]       combo,
  output logic [7:0]       max_combo,
  output logic             overflow,
  output logic             game_done
);

  localparam logic signed [16:0] P_WIN = $signed({1'b0, PERFECT_WIN});
  localparam logic signed [16:0] G_WIN = $signed({1'b0, GOOD_WIN});

  state_t           state;
  logic             ga_q;
  logic [15:0]      now;

  logic             rise;
  logic             fall;
  logic             restart;
  logic             active;
  logic             push;

  logic             full;
  logic             empty;
  logic [LANES-1:0] head_mask;
  logic [15:0]      head_stamp;

  logic [15:0]        target_p0;
  logic signed [15:0] delta_p0;
  logic signed [16:0] delta_x_p0;
  logic [LANES-1:0]   hit_p0;
  logic [LANES-1:0]   rem_next_p0;
  jr_t                jr_p0;
  logic [LANES-1:0]   lanes_p0;
  logic [18:0]        add_p0;
  logic               pop_p0;
  logic               head_we_p0;

  // Saturating score accumulate.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [18:0] b);
    logic [19:0] s;
    s = {4'b0000, a} + {1'b0, b};
    return (s > 20'h0FFFF) ? 16'hFFFF : s[15:0];
  endfunction

  // Saturating combo increment.
  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? 8'hFF : c + 8'd1;
  endfunction

  assign rise    = game_active & ~ga_q;
  assign fall    = ~game_active & ga_q;
  assign restart = rise && (state != S_RUN);
  assign active  = (state == S_RUN || state == S_DRAIN) && !restart;
  assign push    = (state == S_RUN) && !restart && note_valid && (new_note != '0);

  note_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (restart),
    .push       (push),
    .push_mask  (new_note),
    .push_stamp (now),
    .pop        (pop_p0),
    .head_we    (head_we_p0),
    .head_wmask (rem_next_p0),
    .full       (full),
    .empty      (empty),
    .head_mask  (head_mask),
    .head_stamp (head_stamp)
  );

  // Judge decision for the head note against the current time.
  always_comb begin
    target_p0   = head_stamp + TRAVEL_TICKS;
    delta_p0    = $signed(now - target_p0);
    delta_x_p0  = {delta_p0[15], delta_p0};
    hit_p0      = key_press & head_mask;
    rem_next_p0 = head_mask & ~hit_p0;
    jr_p0       = JR_NONE;
    lanes_p0    = '0;
    add_p0      = '0;
    pop_p0      = 1'b0;
    head_we_p0  = 1'b0;
    if (active && !empty) begin
      if (hit_p0 != '0 && delta_x_p0 <= P_WIN && delta_x_p0 >= -P_WIN) begin
        jr_p0      = JR_PERFECT;
        lanes_p0   = hit_p0;
        add_p0     = PERFECT_PTS * popcount_lanes(hit_p0);
        head_we_p0 = 1'b1;
        pop_p0     = (rem_next_p0 == '0);
      end else if (hit_p0 != '0 && delta_x_p0 <= G_WIN && delta_x_p0 >= -G_WIN) begin
        jr_p0      = JR_GOOD;
        lanes_p0   = hit_p0;
        add_p0     = GOOD_PTS * popcount_lanes(hit_p0);
        head_we_p0 = 1'b1;
        pop_p0     = (rem_next_p0 == '0);
      end else if (delta_x_p0 > G_WIN && head_mask != '0) begin
        jr_p0    = JR_MISS;
        lanes_p0 = head_mask;
        pop_p0   = 1'b1;
      end
    end
  end

  // Game FSM, time base, scoring and registered judgement outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ga_q         <= 1'b0;
      now          <= '0;
      score        <= '0;
      combo        <= '0;
      overflow     <= 1'b0;
      game_done    <= 1'b0;
      judge_valid  <= 1'b0;
      judge_result <= JR_NONE;
      judge_lanes  <= '0;
    end else begin
      ga_q         <= game_active;
      game_done    <= 1'b0;
      judge_valid  <= 1'b0;
      judge_result <= JR_NONE;
      judge_lanes  <= '0;
      if (restart) begin
        state    <= S_RUN;
        now      <= '0;
        score    <= '0;
        combo    <= '0;
        overflow <= 1'b0;
      end else begin
        case (state)
          S_IDLE:  state <= S_IDLE;
          S_RUN:   if (fall) state <= S_DRAIN;
          S_DRAIN: begin
            if (empty) begin
              game_done <= 1'b1;
              state     <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
        if (active && tick_en) now <= now + 16'd1;
        if (push && full) overflow <= 1'b1;
        if (jr_p0 != JR_NONE) begin
          judge_valid  <= 1'b1;
          judge_result <= jr_p0;
          judge_lanes  <= lanes_p0;
        end
        if (jr_p0 == JR_PERFECT || jr_p0 == JR_GOOD) begin
          score <= sat_add16(score, add_p0);
          combo <= sat_inc8(combo);
        end else if (jr_p0 == JR_MISS) begin
          combo <= '0;
        end
      end
    end
  end

  // Max combo follows combo one cycle later; cleared at game start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_combo <= '0;
    end else if (restart) begin
      max_combo <= '0;
    end else if (combo > max_combo) begin
      max_combo <= combo;
    end
  end

endmodule
